// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bus: fetch-side prediction capture, EX-side outcome,
// same-cycle redirect and registered predictor-update / perf-counter outputs.
//   master : pipeline side (drives stall/flush/fetch/EX, observes results)
//   slave  : branch_resolve_unit
interface branch_resolve_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             flush_all;
  logic             if_valid;
  logic [31:0]      if_pc;
  logic             if_pred_taken;
  logic [31:0]      if_pred_target;
  logic             ex_is_branch;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      update_PC;
  logic [31:0]      real_target;
  logic             real_taken;
  logic             predict_wrong;
  logic             is_branch;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output stall, flush_all, if_valid, if_pc, if_pred_taken, if_pred_target,
           ex_is_branch, ex_taken, ex_target,
    input  redirect, redirect_pc, update_PC, real_target, real_taken,
           predict_wrong, is_branch, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  stall, flush_all, if_valid, if_pc, if_pred_taken, if_pred_target,
           ex_is_branch, ex_taken, ex_target,
    output redirect, redirect_pc, update_PC, real_target, real_taken,
           predict_wrong, is_branch, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks each fetched prediction through D and E slots
// (mirroring IF/ID and ID/EX), checks it against the EX outcome and emits
// a combinational redirect, a registered predictor-update packet and
// saturating branch / misprediction counters.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - branch_resolve_unit_if.slave (inputs from fetch/EX, outputs
//           redirect, update packet and counters)
module branch_resolve_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_unit_if.slave   bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } slot_t;

  slot_t            d_q, d_d, e_q, e_d;
  logic             res_c, wrong_c;
  logic [31:0]      seq_pc_c, act_next_c, pred_next_c;

  logic [31:0]      upd_pc_q, upd_pc_d;
  logic [31:0]      real_target_q, real_target_d;
  logic             real_taken_q, real_taken_d;
  logic             predict_wrong_q, predict_wrong_d;
  logic             is_branch_q, is_branch_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  // Resolution of the E-slot instruction against the actual outcome
  always_comb begin
    res_c       = e_q.valid & ~bus.stall & ~bus.flush_all;
    seq_pc_c    = e_q.pc + 32'd4;
    act_next_c  = (bus.ex_is_branch & bus.ex_taken) ? bus.ex_target : seq_pc_c;
    pred_next_c = e_q.pred_taken ? e_q.pred_target : seq_pc_c;
    // Comparing next-PCs covers direction, target and aliased non-branches
    wrong_c     = res_c & (pred_next_c != act_next_c);
  end

  assign bus.redirect    = wrong_c;
  assign bus.redirect_pc = res_c ? act_next_c : 32'd0;

  // Slot advance: flush > stall > redirect (kill wrong path) > shift
  always_comb begin
    d_d = d_q;
    e_d = e_q;
    if (bus.flush_all) begin
      d_d.valid = 1'b0;
      e_d.valid = 1'b0;
    end else if (!bus.stall) begin
      e_d = d_q;
      d_d = '{valid:       bus.if_valid,
              pc:          bus.if_pc,
              pred_taken:  bus.if_pred_taken,
              pred_target: bus.if_pred_target};
      if (wrong_c) begin
        e_d.valid = 1'b0;
        d_d.valid = 1'b0;
      end
    end
  end

  // Update packet and saturating counters
  always_comb begin
    upd_pc_d         = upd_pc_q;
    real_target_d    = real_target_q;
    real_taken_d     = 1'b0;
    predict_wrong_d  = 1'b0;
    is_branch_d      = 1'b0;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (res_c) begin
      upd_pc_d        = e_q.pc;
      real_target_d   = bus.ex_target;
      real_taken_d    = bus.ex_is_branch & bus.ex_taken;
      predict_wrong_d = wrong_c;
      is_branch_d     = bus.ex_is_branch;
      if (bus.ex_is_branch && (branch_cnt_q != {CNT_W{1'b1}})) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (wrong_c && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q              <= '0;
      e_q              <= '0;
      upd_pc_q         <= '0;
      real_target_q    <= '0;
      real_taken_q     <= 1'b0;
      predict_wrong_q  <= 1'b0;
      is_branch_q      <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      d_q              <= d_d;
      e_q              <= e_d;
      upd_pc_q         <= upd_pc_d;
      real_target_q    <= real_target_d;
      real_taken_q     <= real_taken_d;
      predict_wrong_q  <= predict_wrong_d;
      is_branch_q      <= is_branch_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.update_PC      = upd_pc_q;
  assign bus.real_target    = real_target_q;
  assign bus.real_taken     = real_taken_q;
  assign bus.predict_wrong  = predict_wrong_q;
  assign bus.is_branch      = is_branch_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule
